// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state encoding,
// parameter defaults and the averaging depth.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE,
    DONE
  } sar_state_e;

  localparam int unsigned SAR_WIDTH_DEFAULT  = 10;
  localparam int unsigned SAR_SETTLE_DEFAULT = 2;
  localparam int unsigned SAR_AVG_COUNT      = 4;

endpackage

// File: rtl/sar_settle_timer.sv
// DAC settle timer: load restarts the count; done is high during the last
// settle cycle so the FSM can step into DECIDE on the following edge.
module sar_settle_timer
  import sar_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SAR_SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam logic [3:0] LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/sar_adc_controller.sv
// Successive-approximation ADC controller (IDLE/SETTLE/DECIDE/DONE FSM).
// Define SAR_AVG4_EN to run 4 back-to-back conversions per start and report their average.
module sar_adc_controller
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = SAR_WIDTH_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SAR_SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  localparam int unsigned      IDX_W     = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] MSB_IDX   = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_BIT   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam sar_state_e       BIT_ENTRY = (SETTLE_CYCLES == 0) ? DECIDE : SETTLE;

  sar_state_e       state;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] code_kept;
  logic             settle_load;
  logic             settle_done;
  logic             last_conv;

`ifdef SAR_AVG4_EN
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] acc_sum;
  logic [1:0]       conv_cnt;
`endif

  always_comb begin
    bit_mask          = '0;
    bit_mask[bit_idx] = 1'b1;
    code_kept         = cmp_in ? dac_code : (dac_code & ~bit_mask);
`ifdef SAR_AVG4_EN
    acc_sum   = acc + {2'b00, code_kept};
    last_conv = (conv_cnt == 2'(SAR_AVG_COUNT - 1));
`else
    last_conv = 1'b1;
`endif
    // The timer restarts on every entry into a bit's settle window.
    settle_load = ((state == IDLE) && start) ||
                  ((state == DECIDE) && ((bit_idx != '0) || !last_conv));
  end

  sar_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .reset(reset),
    .load (settle_load),
    .done (settle_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_idx  <= '0;
      dac_code <= '0;
      result   <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
`ifdef SAR_AVG4_EN
      acc      <= '0;
      conv_cnt <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= BIT_ENTRY;
            bit_idx  <= MSB_IDX;
            dac_code <= MSB_BIT;
            busy     <= 1'b1;
`ifdef SAR_AVG4_EN
            acc      <= '0;
            conv_cnt <= '0;
`endif
          end
        end
        SETTLE: begin
          if (settle_done) state <= DECIDE;
        end
        DECIDE: begin
          if (bit_idx != '0) begin
            dac_code <= code_kept | (bit_mask >> 1);
            bit_idx  <= bit_idx - IDX_W'(1);
            state    <= BIT_ENTRY;
          end else begin
`ifdef SAR_AVG4_EN
            acc <= acc_sum;
            if (last_conv) begin
              result   <= acc_sum[WIDTH+1:2];
              valid    <= 1'b1;
              dac_code <= code_kept;
              state    <= DONE;
            end else begin
              conv_cnt <= conv_cnt + 2'd1;
              bit_idx  <= MSB_IDX;
              dac_code <= MSB_BIT;
              state    <= BIT_ENTRY;
            end
`else
            result   <= code_kept;
            valid    <= 1'b1;
            dac_code <= code_kept;
            state    <= DONE;
`endif
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          dac_code <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_controller.sv
// Bench for sar_adc_controller: ideal comparator, binary-search reference model,
// table-driven and random conversions, plus reset-abort and averaging sequences.
module tb_sar_adc_controller;

  localparam int W = 10;
`ifdef SAR_AVG4_EN
  localparam int NAVG = 4;
`else
  localparam int NAVG = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_d, start_z;
  int          vin_code;
  logic [W-1:0] dac_d, dac_z, res_d, res_z;
  logic        busy_d, busy_z, valid_d, valid_z;
  logic        cmp_d, cmp_z;
  logic        sel_z;
  logic [W-1:0] cur_dac, cur_res;
  logic        cur_busy, cur_valid;

  assign cmp_d = (vin_code >= int'(dac_d));
  assign cmp_z = (vin_code >= int'(dac_z));

  sar_adc_controller #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start_d), .cmp_in(cmp_d),
    .dac_code(dac_d), .busy(busy_d), .result(res_d), .valid(valid_d)
  );

  sar_adc_controller #(.WIDTH(W), .SETTLE_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .start(start_z), .cmp_in(cmp_z),
    .dac_code(dac_z), .busy(busy_z), .result(res_z), .valid(valid_z)
  );

  always_comb begin
    cur_dac   = sel_z ? dac_z   : dac_d;
    cur_res   = sel_z ? res_z   : res_d;
    cur_busy  = sel_z ? busy_z  : busy_d;
    cur_valid = sel_z ? valid_z : valid_d;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Ideal SAR outcome: greedy binary search against an ideal comparator.
  function automatic int ideal_code(input int vin);
    int code = 0;
    for (int b = W - 1; b >= 0; b--)
      if (vin >= (code | (1 << b))) code = code | (1 << b);
    return code;
  endfunction

  // k-th trial level presented to the DAC (k = 0 is the MSB trial).
  function automatic int trial_at(input int vin, input int k);
    int code = 0;
    for (int i = 0; i < k; i++) begin
      int b = W - 1 - i;
      if (vin >= (code | (1 << b))) code = code | (1 << b);
    end
    return code | (1 << (W - 1 - k));
  endfunction

  task automatic set_start(input bit z, input logic v);
    if (z) start_z = v;
    else   start_d = v;
  endtask

  task automatic run_conv(input bit z, input int vin0, input int step, input int exp_res,
                          input int xs1, input int xs2, input string tag);
    int s           = z ? 0 : 2;
    int per         = W * (s + 1);
    int lat         = NAVG * per + 1;
    int first_valid = -1;
    int nvalid      = 0;
    int busy_err    = 0;
    int trial_err   = 0;
    int conv;
    sel_z    = z;
    vin_code = vin0;
    @(negedge clk);
    set_start(z, 1'b1);
    @(posedge clk);
    #1;
    set_start(z, 1'b0);
    for (int cyc = 1; cyc <= lat + 4; cyc++) begin
      conv     = (cyc - 1) / per;
      if (conv > NAVG - 1) conv = NAVG - 1;
      vin_code = vin0 + step * conv;
      if (cur_valid === 1'b1) begin
        nvalid++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (cur_busy !== (cyc <= lat)) busy_err++;
      if (cyc <= per && ((cyc - 1) % (s + 1)) == 0)
        if (int'(cur_dac) != trial_at(vin0, (cyc - 1) / (s + 1))) trial_err++;
      set_start(z, (cyc == xs1 || cyc == xs2));
      @(posedge clk);
      #1;
    end
    set_start(z, 1'b0);
    check({tag, " valid_count"}, nvalid, 1);
    check({tag, " valid_cycle"}, first_valid, lat);
    check({tag, " result"}, cur_res, exp_res);
    check({tag, " busy_window_errors"}, busy_err, 0);
    check({tag, " trial_seq_errors"}, trial_err, 0);
    check({tag, " dac_idle"}, cur_dac, 0);
  endtask

  typedef struct {
    int vin;
    bit z;
    int exp;
    int xs1;
    int xs2;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int rv;
    int nv;
    vecs[0] = '{677,  1'b0, 677,  -1, -1};
    vecs[1] = '{1023, 1'b0, 1023, -1, -1};
    vecs[2] = '{0,    1'b0, 0,    -1, -1};
    vecs[3] = '{512,  1'b0, 512,  -1, -1};
    vecs[4] = '{511,  1'b0, 511,  -1, -1};
    vecs[5] = '{300,  1'b1, 300,  -1, -1};
    vecs[6] = '{1,    1'b1, 1,    -1, -1};
    vecs[7] = '{677,  1'b0, 677,  5,  20};

    reset = 1'b1; start_d = 1'b0; start_z = 1'b0; vin_code = 0; sel_z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dac_code", dac_d, 0);
    check("reset busy", busy_d, 0);
    check("reset valid", valid_d, 0);
    check("reset result", res_d, 0);
    check("reset z busy", busy_z, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++)
      run_conv(vecs[i].z, vecs[i].vin, 0, vecs[i].exp, vecs[i].xs1, vecs[i].xs2,
               $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv = int'($urandom_range(0, 1023));
      run_conv(i[0], rv, 0, ideal_code(rv), -1, -1, $sformatf("rand%0d", i));
    end

    // Reset in cycle 15 of a conversion must abort it without a valid pulse.
    sel_z = 1'b0; vin_code = 677; nv = 0;
    @(negedge clk);
    start_d = 1'b1;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    for (int cyc = 1; cyc < 15; cyc++) begin
      if (valid_d === 1'b1) nv++;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort dac_code", dac_d, 0);
    check("abort busy", busy_d, 0);
    check("abort valid", valid_d, 0);
    check("abort result", res_d, 0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (valid_d === 1'b1 || busy_d === 1'b1) nv++;
      @(posedge clk);
      #1;
    end
    check("abort no_valid_or_busy", nv, 0);
    run_conv(1'b0, 300, 0, 300, -1, -1, "post_reset");

`ifdef SAR_AVG4_EN
    run_conv(1'b0, 500, 1, 501, -1, -1, "avg4");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
